// File: rtl/core_pkg.sv
// core_pkg: encodings shared by the multi-cycle control FSM, the opcode
// decoder and the immediate generator.
//   - opcode constants for the supported RV32I subset
//   - imm_sel encodings (IMM_R/I/S/B)
//   - alu_op encodings
//   - FSM state enum and latched opcode-class enum
package core_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  typedef enum logic [1:0] {
    IMM_R = 2'b00,
    IMM_I = 2'b01,
    IMM_S = 2'b10,
    IMM_B = 2'b11
  } imm_sel_e;

  typedef enum logic [1:0] {
    ALU_ADD   = 2'b00,
    ALU_SUB   = 2'b01,
    ALU_FUNCT = 2'b10
  } alu_op_e;

  typedef enum logic [2:0] {
    START  = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    MEM    = 3'd4,
    WB     = 3'd5
  } state_e;

  typedef enum logic [2:0] {
    CLS_R      = 3'd0,
    CLS_I      = 3'd1,
    CLS_LOAD   = 3'd2,
    CLS_STORE  = 3'd3,
    CLS_BRANCH = 3'd4
  } op_class_e;

  // Immediate format implied by an opcode class; loads use the I format.
  function automatic imm_sel_e imm_of(input op_class_e cls);
    case (cls)
      CLS_I, CLS_LOAD: imm_of = IMM_I;
      CLS_STORE:       imm_of = IMM_S;
      CLS_BRANCH:      imm_of = IMM_B;
      default:         imm_of = IMM_R;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// multicycle_ctrl_if: bundle between the control FSM and the datapath /
// instruction and data memories.
//   master : the controller (consumes instr, readies, alu_zero; drives strobes)
//   slave  : the datapath side (the reverse view)
interface multicycle_ctrl_if #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
);
  logic [XLEN-1:0]  instr;
  logic             imem_ready;
  logic             dmem_ready;
  logic             alu_zero;
  logic             imem_req;
  logic             ir_write;
  logic [1:0]       imm_sel;
  logic             alu_src_imm;
  logic [1:0]       alu_op;
  logic             dmem_read;
  logic             dmem_write;
  logic             reg_write;
  logic             wb_sel_mem;
  logic             pc_write;
  logic             pc_branch;
  logic             illegal;
  logic [CNT_W-1:0] retired;

  modport master (
    input  instr, imem_ready, dmem_ready, alu_zero,
    output imem_req, ir_write, imm_sel, alu_src_imm, alu_op, dmem_read,
           dmem_write, reg_write, wb_sel_mem, pc_write, pc_branch, illegal,
           retired
  );

  modport slave (
    output instr, imem_ready, dmem_ready, alu_zero,
    input  imem_req, ir_write, imm_sel, alu_src_imm, alu_op, dmem_read,
           dmem_write, reg_write, wb_sel_mem, pc_write, pc_branch, illegal,
           retired
  );
endinterface

// File: rtl/opcode_decode.sv
// opcode_decode: combinational map from instr[6:0] to an opcode class.
//   opcode   in  7  instr[6:0]
//   op_class out    class of a supported opcode (don't-care when illegal)
//   illegal  out 1  opcode is not in the supported subset
module opcode_decode
  import core_pkg::*;
(
  input  logic [6:0] opcode,
  output op_class_e  op_class,
  output logic       illegal
);

  always_comb begin
    // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
    op_class = CLS_R;
    illegal  = 1'b0;
    case (opcode)
      OP_R:      op_class = CLS_R;
      OP_I:      op_class = CLS_I;
      OP_LOAD:   op_class = CLS_LOAD;
      OP_STORE:  op_class = CLS_STORE;
      OP_BRANCH: op_class = CLS_BRANCH;
      default:   illegal  = 1'b1;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: multi-cycle control FSM for the RV32I-subset core.
// Sequences START -> FETCH -> DECODE -> EXEC -> [MEM] -> [WB] -> FETCH.
//   clk  in   single clock, rising edge
//   rst  in   asynchronous, active-high reset
//   bus  master view of multicycle_ctrl_if:
//        in  instr, imem_ready, dmem_ready, alu_zero
//        out imem_req, ir_write, pc_write, imm_sel, alu_src_imm, alu_op,
//            dmem_read, dmem_write, reg_write, wb_sel_mem, pc_branch,
//            illegal, retired
module multicycle_ctrl
  import core_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  multicycle_ctrl_if.master   bus
);

  state_e           state, state_nxt;
  op_class_e        cls_q;
  op_class_e        dec_cls;
  logic             dec_illegal;
  logic [1:0]       imm_sel_q;
  logic [CNT_W-1:0] retired_q;
  logic             retire;

  logic       imem_req, ir_write, pc_write, alu_src_imm;
  logic [1:0] alu_op;
  logic       dmem_read, dmem_write, reg_write, wb_sel_mem, pc_branch, illegal;

  // Only the opcode field steers control; the rest goes to the datapath.
  logic unused_instr_hi;
  assign unused_instr_hi = ^bus.instr[XLEN-1:7];

  opcode_decode u_dec (
    .opcode   (bus.instr[6:0]),
    .op_class (dec_cls),
    .illegal  (dec_illegal)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    if (rst) state <= START;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      START:  state_nxt = FETCH;
      FETCH:  state_nxt = bus.imem_ready ? DECODE : FETCH;
      DECODE: state_nxt = dec_illegal ? FETCH : EXEC;
      EXEC: begin
        case (cls_q)
          CLS_LOAD, CLS_STORE: state_nxt = MEM;
          CLS_BRANCH:          state_nxt = FETCH;
          default:             state_nxt = WB;
        endcase
      end
      MEM: begin
        if (bus.dmem_ready) state_nxt = (cls_q == CLS_LOAD) ? WB : FETCH;
      end
      WB:      state_nxt = FETCH;
      default: state_nxt = START;
    endcase
  end

  // Output logic: Moore on state + latched class, except the ready/zero gated
  // strobes in FETCH and for BEQ.
  always_comb begin
    imem_req    = 1'b0;
    ir_write    = 1'b0;
    pc_write    = 1'b0;
    alu_src_imm = 1'b0;
    alu_op      = ALU_ADD;
    dmem_read   = 1'b0;
    dmem_write  = 1'b0;
    reg_write   = 1'b0;
    wb_sel_mem  = 1'b0;
    pc_branch   = 1'b0;
    illegal     = 1'b0;
    case (state)
      FETCH: begin
        imem_req = 1'b1;
        ir_write = bus.imem_ready;
        pc_write = bus.imem_ready;
      end
      DECODE: illegal = dec_illegal;
      EXEC: begin
        case (cls_q)
          CLS_R: alu_op = ALU_FUNCT;
          CLS_I: begin
            alu_op      = ALU_FUNCT;
            alu_src_imm = 1'b1;
          end
          CLS_LOAD, CLS_STORE: alu_src_imm = 1'b1;
          CLS_BRANCH: begin
            alu_op    = ALU_SUB;
            pc_branch = bus.alu_zero;
          end
          default: ;
        endcase
      end
      MEM: begin
        dmem_read  = (cls_q == CLS_LOAD);
        dmem_write = (cls_q == CLS_STORE);
      end
      WB: begin
        reg_write  = 1'b1;
        wb_sel_mem = (cls_q == CLS_LOAD);
      end
      default: ;
    endcase
  end

  // Opcode class and imm_sel are captured together at the end of a legal
  // DECODE and held until the next one, so the immediate generator sees the
  // latched instruction's format for EXEC/MEM/WB.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cls_q     <= CLS_R;
      imm_sel_q <= IMM_R;
    end else if (state == DECODE && !dec_illegal) begin
      cls_q     <= dec_cls;
      imm_sel_q <= imm_of(dec_cls);
    end
  end

  // One retirement per instruction, on the cycle it leaves its final state.
  // A store leaves MEM only with dmem_ready, so that single term counts it.
  assign retire = (state == WB)
               || (state == EXEC && cls_q == CLS_BRANCH)
               || (state == MEM  && cls_q == CLS_STORE && bus.dmem_ready);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)         retired_q <= '0;
    else if (retire) retired_q <= retired_q + 1'b1;  // wraps naturally
  end

  assign bus.imem_req    = imem_req;
  assign bus.ir_write    = ir_write;
  assign bus.pc_write    = pc_write;
  assign bus.imm_sel     = imm_sel_q;
  assign bus.alu_src_imm = alu_src_imm;
  assign bus.alu_op      = alu_op;
  assign bus.dmem_read   = dmem_read;
  assign bus.dmem_write  = dmem_write;
  assign bus.reg_write   = reg_write;
  assign bus.wb_sel_mem  = wb_sel_mem;
  assign bus.pc_branch   = pc_branch;
  assign bus.illegal     = illegal;
  assign bus.retired     = retired_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: directed self-checking bench for multicycle_ctrl.
// Main instance uses CNT_W=32; a second instance with CNT_W=2 exercises the
// retired-counter wrap after three retirements bring it to its maximum.
module tb_multicycle_ctrl;
  import core_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic rst2;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  multicycle_ctrl_if #(.XLEN(32), .CNT_W(32)) bus ();
  multicycle_ctrl_if #(.XLEN(32), .CNT_W(2))  bus2 ();

  multicycle_ctrl #(.XLEN(32), .CNT_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  multicycle_ctrl #(.XLEN(32), .CNT_W(2)) dut2 (
    .clk (clk),
    .rst (rst2),
    .bus (bus2.master)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Concatenation of every 1-bit strobe of the main instance.
  function automatic logic [31:0] strobes();
    return {21'd0, bus.imem_req, bus.ir_write, bus.pc_write, bus.alu_src_imm,
            bus.dmem_read, bus.dmem_write, bus.reg_write, bus.wb_sel_mem,
            bus.pc_branch, bus.illegal, 1'b0};
  endfunction

  localparam logic [31:0] I_LW   = 32'h0000_2083;
  localparam logic [31:0] I_ADDI = 32'h0050_0093;
  localparam logic [31:0] I_SW   = 32'h0011_2223;
  localparam logic [31:0] I_BEQ  = 32'h0000_0063;
  localparam logic [31:0] I_ADD  = 32'h0020_81b3;
  localparam logic [31:0] I_BAD  = 32'h0000_007f;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int wr_cycles;
    rst  = 1'b1;
    rst2 = 1'b1;
    bus.instr = I_LW;   bus.imem_ready = 1'b1; bus.dmem_ready = 1'b0; bus.alu_zero = 1'b0;
    bus2.instr = I_ADDI; bus2.imem_ready = 1'b1; bus2.dmem_ready = 1'b1; bus2.alu_zero = 1'b0;

    // ---- reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_strobes", strobes(), 32'd0);
    check("rst_imm_sel", 32'(bus.imm_sel), 32'd0);
    check("rst_alu_op", 32'(bus.alu_op), 32'd0);
    check("rst_retired", bus.retired, 32'd0);
    rst = 1'b0;
    check("start_no_req", 32'(bus.imem_req), 32'd0);

    // ---- LOAD aborted by reset mid-MEM
    cyc();  // FETCH
    check("lw_fetch_ir_write", 32'(bus.ir_write), 32'd1);
    check("lw_fetch_pc_write", 32'(bus.pc_write), 32'd1);
    cyc();  // DECODE
    check("lw_dec_illegal", 32'(bus.illegal), 32'd0);
    cyc();  // EXEC
    check("lw_exec_imm_sel", 32'(bus.imm_sel), 32'(IMM_I));
    check("lw_exec_alu_op", 32'(bus.alu_op), 32'(ALU_ADD));
    check("lw_exec_src_imm", 32'(bus.alu_src_imm), 32'd1);
    cyc();  // MEM
    check("lw_mem_read", 32'(bus.dmem_read), 32'd1);
    cyc();  // MEM, still waiting
    check("lw_mem_read_held", 32'(bus.dmem_read), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("abort_strobes", strobes(), 32'd0);
    check("abort_state", 32'(dut.state), 32'(START));
    check("abort_retired", bus.retired, 32'd0);
    check("abort_imm_sel", 32'(bus.imm_sel), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    check("release_start", 32'(bus.imem_req), 32'd0);
    cyc();
    check("release_fetch", 32'(bus.imem_req), 32'd1);

    // ---- ADDI x1,x0,5 with readies high (dmem_ready high is ignored)
    bus.instr = I_ADDI;
    bus.dmem_ready = 1'b1;
    check("addi_c1_ir_write", 32'(bus.ir_write), 32'd1);
    cyc();  // c2 DECODE
    check("addi_c2_imm_sel", 32'(bus.imm_sel), 32'(IMM_R));
    cyc();  // c3 EXEC
    check("addi_c3_imm_sel", 32'(bus.imm_sel), 32'(IMM_I));
    check("addi_c3_src_imm", 32'(bus.alu_src_imm), 32'd1);
    check("addi_c3_alu_op", 32'(bus.alu_op), 32'(ALU_FUNCT));
    check("addi_c3_no_dmem", 32'({bus.dmem_read, bus.dmem_write}), 32'd0);
    cyc();  // c4 WB
    check("addi_c4_reg_write", 32'(bus.reg_write), 32'd1);
    check("addi_c4_wb_sel", 32'(bus.wb_sel_mem), 32'd0);
    check("addi_c4_retired", bus.retired, 32'd0);
    cyc();  // FETCH
    check("addi_retired", bus.retired, 32'd1);
    check("addi_back_fetch", 32'(bus.imem_req), 32'd1);

    // ---- SW with dmem_ready low for 3 cycles
    bus.instr = I_SW;
    bus.dmem_ready = 1'b0;
    cyc();  // c2 DECODE
    cyc();  // c3 EXEC
    check("sw_imm_sel", 32'(bus.imm_sel), 32'(IMM_S));
    check("sw_alu_op", 32'(bus.alu_op), 32'(ALU_ADD));
    check("sw_src_imm", 32'(bus.alu_src_imm), 32'd1);
    wr_cycles = 0;
    for (int i = 0; i < 4; i++) begin
      cyc();  // c4..c7 MEM
      if (i == 3) bus.dmem_ready = 1'b1;
      #1;
      if (bus.dmem_write === 1'b1) wr_cycles++;
      check("sw_no_reg_write", 32'(bus.reg_write), 32'd0);
      check("sw_no_read", 32'(bus.dmem_read), 32'd0);
    end
    check("sw_write_cycles", 32'(wr_cycles), 32'd4);
    check("sw_c7_retired", bus.retired, 32'd1);
    cyc();  // FETCH after 7 cycles
    check("sw_retired", bus.retired, 32'd2);
    check("sw_back_fetch", 32'(bus.imem_req), 32'd1);

    // ---- BEQ taken, then not taken
    for (int k = 0; k < 2; k++) begin
      bus.instr = I_BEQ;
      bus.alu_zero = (k == 0);
      cyc();  // DECODE
      cyc();  // EXEC
      check("beq_imm_sel", 32'(bus.imm_sel), 32'(IMM_B));
      check("beq_alu_op", 32'(bus.alu_op), 32'(ALU_SUB));
      check("beq_src_imm", 32'(bus.alu_src_imm), 32'd0);
      check("beq_pc_branch", 32'(bus.pc_branch), (k == 0) ? 32'd1 : 32'd0);
      check("beq_no_reg_write", 32'(bus.reg_write), 32'd0);
      cyc();  // FETCH after 3 cycles
      check("beq_retired", bus.retired, 32'(3 + k));
      check("beq_back_fetch", 32'(bus.imem_req), 32'd1);
    end
    bus.alu_zero = 1'b0;

    // ---- illegal opcode 0x7F, with one instruction-memory stall first
    bus.instr = I_BAD;
    bus.imem_ready = 1'b0;
    #1;
    check("stall_req", 32'(bus.imem_req), 32'd1);
    check("stall_ir_write", 32'(bus.ir_write), 32'd0);
    check("stall_pc_write", 32'(bus.pc_write), 32'd0);
    cyc();  // still FETCH
    bus.imem_ready = 1'b1;
    #1;
    check("stall_done_ir_write", 32'(bus.ir_write), 32'd1);
    cyc();  // DECODE
    check("bad_illegal", 32'(bus.illegal), 32'd1);
    cyc();  // FETCH
    check("bad_illegal_pulse", 32'(bus.illegal), 32'd0);
    check("bad_back_fetch", 32'(bus.imem_req), 32'd1);
    check("bad_retired", bus.retired, 32'd4);
    check("bad_imm_sel_held", 32'(bus.imm_sel), 32'(IMM_B));

    // ---- counter wrap on the CNT_W=2 instance
    @(posedge clk);
    #1 rst2 = 1'b0;
    cyc();  // FETCH
    for (int n = 0; n < 3; n++) begin
      repeat (4) cyc();  // DECODE, EXEC, WB, FETCH
    end
    check("wrap_preload", 32'(bus2.retired), 32'd3);
    bus2.instr = I_ADD;
    cyc();  // DECODE
    cyc();  // EXEC
    check("r_imm_sel", 32'(bus2.imm_sel), 32'(IMM_R));
    check("r_src_imm", 32'(bus2.alu_src_imm), 32'd0);
    check("r_alu_op", 32'(bus2.alu_op), 32'(ALU_FUNCT));
    cyc();  // WB
    check("r_reg_write", 32'(bus2.reg_write), 32'd1);
    cyc();  // FETCH
    check("wrap_retired", 32'(bus2.retired), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Multi-cycle control FSM for the RV32I-subset core. It sequences each instruction through fetch, decode, execute, memory and writeback. It drives the immediate-generator select so immediates match the latched opcode, and issues register-file, ALU, PC and memory strobes. It sits between the instruction register and the datapath, and handshakes with the instruction and data memories.

## Interface
- `XLEN`, 32, instruction width.
- `CNT_W`, 32, width of the retired-instruction counter.

- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `instr`  in  XLEN  instruction word from the IR, valid from DECODE onward.
- `imem_ready`  in  1  instruction memory has data this cycle.
- `dmem_ready`  in  1  data memory access complete this cycle.
- `alu_zero`  in  1  ALU zero flag, valid in EXEC.
- `imem_req`  out  1  instruction fetch request.
- `ir_write`  out  1  latch instr into the IR.
- `imm_sel`  out  2  immediate select: 00 R, 01 I, 10 S, 11 B.
- `alu_src_imm`  out  1  ALU operand B is the immediate.
- `alu_op`  out  2  00 add, 01 sub (branch compare), 10 funct-decoded.
- `dmem_read`  out  1  load request.
- `dmem_write`  out  1  store request.
- `reg_write`  out  1  register-file write enable.
- `wb_sel_mem`  out  1  writeback data comes from memory.
- `pc_write`  out  1  PC <= PC+4.
- `pc_branch`  out  1  PC <= PC+imm.
- `illegal`  out  1  one-cycle pulse when the opcode is unsupported.
- `retired`  out  CNT_W  count of completed instructions.

## Operation
- Supported opcodes:
  - R = 0110011
  - I-ALU = 0010011
  - LOAD = 0000011
  - STORE = 0100011
  - BRANCH = 1100011 (BEQ only; funct3 is ignored)
- States are START, FETCH, DECODE, EXEC, MEM, WB.
- START: all outputs 0. Unconditionally goes to FETCH on the next cycle. This is the reset state.
- FETCH:
  - `imem_req`=1 until `imem_ready`=1.
  - On the cycle where `imem_ready`=1: `ir_write`=1 and `pc_write`=1, then go to DECODE.
  - Otherwise stay in FETCH with all other strobes 0.
- DECODE: latch opcode class into a register and set `imm_sel` from it: R→00, I-ALU/LOAD→01, STORE→10, BRANCH→11.
  - Unsupported opcode: `illegal`=1 for this cycle, go to FETCH. `retired` does not increment.
- EXEC:
  - R: `alu_op`=10, `alu_src_imm`=0, then WB.
  - I-ALU: `alu_op`=10, `alu_src_imm`=1, then WB.
  - LOAD/STORE: `alu_op`=00, `alu_src_imm`=1, then MEM.
  - BRANCH: `alu_op`=01, `alu_src_imm`=0; `pc_branch`=`alu_zero`; then FETCH. Retires.
- MEM:
  - LOAD: `dmem_read`=1 until `dmem_ready`, then WB.
  - STORE: `dmem_write`=1 until `dmem_ready`, then FETCH. Retires.
  - The strobe is held constant while waiting.
- WB: `reg_write`=1, `wb_sel_mem`=1 for LOAD only, then FETCH. Retires.
- `imm_sel` is registered: it updates at the end of DECODE and holds its value until the next DECODE.
- Retirement: `retired` increments by 1 on the cycle the instruction leaves its last state. It wraps from 2^CNT_W−1 to 0.

## Timing
- Reset values while `rst`=1:
  - state = START
  - all strobes = 0, `imm_sel`=00, `retired`=0
- Reset asserted mid-instruction aborts it immediately: strobes drop asynchronously and nothing retires.
- All strobes are Moore outputs, decoded from state plus the registered opcode class. The exceptions are `ir_write`/`pc_write` (gated by `imem_ready`) and `pc_branch` (gated by `alu_zero`).
- Minimum latency from FETCH entry to retirement, with ready inputs tied high:
  - BRANCH: 3 cycles
  - R/I-ALU/STORE: 4 cycles
  - LOAD: 5 cycles
- Each cycle of ready deasserted adds one cycle.
- `imem_ready` or `dmem_ready` asserted outside its request state is ignored.
- Simultaneous `dmem_ready` and a pending retirement: exactly one increment per instruction.

## Structure
- Shared package `core_pkg` holds:
  - opcode constants
  - `imm_sel` encodings (IMM_R/I/S/B)
  - `alu_op` encodings
  - state enum
- The immediate generator consumes the same `imm_sel` encodings.
- Sub-module `opcode_decode`: combinational; maps `instr[6:0]` to an opcode class and an illegal flag. The FSM and retirement counter stay in the top module.

## Test plan
- Reset mid-MEM of a LOAD:
  - Stimulus: `rst` pulse while `dmem_read`=1.
  - Required: outputs drop to 0 asynchronously, state is START, `retired` unchanged at 0, then FETCH one cycle after release.
- ADDI x1,x0,5 (0x00500093) with ready inputs tied high:
  - Required: `imm_sel`=01 from cycle 3, `alu_src_imm`=1 in EXEC, `reg_write`=1 in cycle 4, `retired` 0→1.
- SW (0x00112223) with `dmem_ready` low for 3 cycles:
  - Required: `imm_sel`=10, `dmem_write` held 4 cycles, no `reg_write`, retires after 7 cycles.
- BEQ with `alu_zero`=1, then again with `alu_zero`=0:
  - Required: `imm_sel`=11; `pc_branch`=1 only in the first case; each retires in 3 cycles.
- Opcode 0x7F:
  - Required: `illegal` pulse in DECODE, return to FETCH, `retired` unchanged.
- Preload counter to 2^CNT_W−1 and retire one R-type:
  - Required: `retired`=0.
